// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for packed BCD input.
// Only a value held steady for STABLE_CYCLES cycles reaches the display; outputs are registered.
module bcd_display_scan #(
    parameter int REFRESH_DIV   = 50000,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic        blank_en,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [15:0]      cand_q, cand_d;
    logic [15:0]      shown_q, shown_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;
    logic             blank;

    // Stability filter: any change restarts the count, so conversion transients never land in shown.
    always_comb begin
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        shown_d      = shown_q;
        if (bcd_in != cand_q) begin
            cand_d       = bcd_in;
            stable_cnt_d = '0;
        end else if (stable_cnt_q < CNT_LAST) begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end else begin
            shown_d = cand_q;
        end
    end

    always_comb begin
        div_cnt_d   = div_cnt_q + DIV_W'(1);
        digit_idx_d = digit_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
    end

    always_comb begin
        nib   = shown_q[{digit_idx_q, 2'b00} +: 4];
        blank = 1'b0;
        case (digit_idx_q)
            2'd1:    blank = blank_en && (shown_q[15:4] == 12'h000);
            2'd2:    blank = blank_en && (shown_q[15:8] == 8'h00);
            2'd3:    blank = blank_en && (shown_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    // Segment order {g,f,e,d,c,b,a}, active low; non-decimal nibbles show a dash.
    always_comb begin
        case (nib)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase
    end

    always_comb begin
        an_d  = ~(4'b0001 << digit_idx_q);
        seg_d = seg_dec;
        if (blank) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q       <= '0;
            shown_q      <= '0;
            stable_cnt_q <= '0;
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
        end else begin
            cand_q       <= cand_d;
            shown_q      <= shown_d;
            stable_cnt_q <= stable_cnt_d;
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV = 4, STABLE_CYCLES = 16.
// Output slot for edge n after reset release is ((n-1)/4) mod 4.
module tb_bcd_display_scan;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SD   = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        blank_en;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [15:0] glitch_vals [13] = '{16'h0001, 16'h0102, 16'h0420, 16'h0033, 16'h1000,
                                      16'h0041, 16'h0040, 16'h0081, 16'h0004, 16'h0043,
                                      16'h0041, 16'h0002, 16'h0040};

    bcd_display_scan #(
        .REFRESH_DIV(4),
        .STABLE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bcd_in(bcd_in),
        .blank_en(blank_en),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        edge_n++;
    endtask

    task automatic check_cycle(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] bmask);
        int slot;
        logic [6:0] es;
        logic [3:0] ea;
        slot = ((edge_n - 1) >> 2) & 3;
        case (slot)
            0:       es = s0;
            1:       es = s1;
            2:       es = s2;
            default: es = s3;
        endcase
        ea = ~(4'b0001 << slot);
        if (bmask[slot]) begin
            ea = 4'b1111;
            es = SOFF;
        end
        check({tag, "_an"}, {12'h000, an}, {12'h000, ea});
        check({tag, "_seg"}, {9'h000, seg}, {9'h000, es});
    endtask

    task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] bmask);
        for (int i = 0; i < 16; i++) begin
            step();
            check_cycle(tag, s0, s1, s2, s3, bmask);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bcd_in   = 16'h0000;
        blank_en = 1'b1;

        // Reset and power-up with leading-zero blanking
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", {12'h000, an}, 16'h000F);
            check("rst_seg", {9'h000, seg}, 16'h007F);
        end
        reset  = 1'b0;
        edge_n = 0;
        frame("pwr", S0, S0, S0, S0, 4'b1110);

        // Steady value with exact filter latency
        bcd_in = 16'h8191;
        for (int i = 0; i < 17; i++) begin
            step();
            check_cycle("lat_old", S0, S0, S0, S0, 4'b1110);
        end
        step();
        check_cycle("lat_new", S1, S9, S1, S8, 4'b0000);
        frame("steady", S1, S9, S1, S8, 4'b0000);

        // Conversion glitches never reach the display
        for (int i = 0; i < 13; i++) begin
            bcd_in = glitch_vals[i];
            step();
            check_cycle("glitch", S1, S9, S1, S8, 4'b0000);
        end
        bcd_in = 16'h0042;
        for (int i = 0; i < 17; i++) begin
            step();
            check_cycle("settle_old", S1, S9, S1, S8, 4'b0000);
        end
        step();
        check_cycle("settle_new", S2, S4, S0, S0, 4'b1100);
        frame("settled", S2, S4, S0, S0, 4'b1100);

        // Change on the cycle the count saturates: no update
        bcd_in = 16'h0033;
        for (int i = 0; i < 16; i++) begin
            step();
            check_cycle("late_chg", S2, S4, S0, S0, 4'b1100);
        end
        bcd_in = 16'h0042;
        for (int i = 0; i < 20; i++) begin
            step();
            check_cycle("late_chg_after", S2, S4, S0, S0, 4'b1100);
        end

        // Invalid nibble, then blank_en toggle with no extra latency
        blank_en = 1'b0;
        bcd_in   = 16'h00A5;
        repeat (18) step();
        frame("invalid", S5, SD, S0, S0, 4'b0000);
        blank_en = 1'b1;
        step();
        check_cycle("blank_on", S5, SD, S0, S0, 4'b1100);
        frame("invalid_blank", S5, SD, S0, S0, 4'b1100);

        // Blanking disabled shows leading zeros
        blank_en = 1'b0;
        bcd_in   = 16'h0007;
        repeat (18) step();
        frame("noblank", S7, S0, S0, S0, 4'b0000);
        blank_en = 1'b1;
        step();
        check_cycle("blank7", S7, S0, S0, S0, 4'b1110);

        // Reset while the digit-2 slot is lit
        blank_en = 1'b0;
        bcd_in   = 16'h1234;
        repeat (18) step();
        frame("pre_rst", S4, S3, S2, S1, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            if ((((edge_n - 1) >> 2) & 3) == 2) break;
            step();
        end
        check("slot2_an", {12'h000, an}, 16'h000B);
        check("slot2_seg", {9'h000, seg}, {9'h000, S2});
        reset = 1'b1;
        step();
        check("midrst_an", {12'h000, an}, 16'h000F);
        check("midrst_seg", {9'h000, seg}, 16'h007F);
        step();
        check("midrst2_an", {12'h000, an}, 16'h000F);
        reset  = 1'b0;
        edge_n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_cycle("rst_zero", S0, S0, S0, S0, 4'b0000);
        end
        repeat (10) step();
        frame("post_rst", S4, S3, S2, S1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
